// File: rtl/enemy_action_scheduler.sv
// Enemy action scheduler: one tick divider owns move timing and the
// windup -> strike -> recover attack cadence, gated by the sprite-draw handshake.
module enemy_action_scheduler #(
  parameter int unsigned CALM_DIV      = 50_000_000,
  parameter int unsigned AGGR_DIV      = 25_000_000,
  parameter int unsigned CALM_MOVES    = 4,
  parameter int unsigned AGGR_MOVES    = 2,
  parameter int unsigned WINDUP_TICKS  = 2,
  parameter int unsigned RECOVER_TICKS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       aggressive,
  input  logic       dead,
  output logic       move_pulse,
  output logic       draw_req,
  input  logic       draw_done,
  output logic       telegraph,
  output logic       strike_valid,
  input  logic       strike_ready,
  output logic [3:0] strike_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    MOVE    = 3'd1,
    DRAW    = 3'd2,
    WINDUP  = 3'd3,
    STRIKE  = 3'd4,
    RECOVER = 3'd5,
    DEAD    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] div_q, div_d;
  logic [2:0]  move_cnt_q, move_cnt_d;
  logic [3:0]  phase_cnt_q, phase_cnt_d;
  logic [3:0]  strike_count_q, strike_count_d;
  logic        move_pulse_q, draw_req_q, telegraph_q, strike_valid_q;

  logic        running;
  logic        tick;
  logic [27:0] reload_val;
  logic [2:0]  move_thresh;
  logic        timed_state_d;

  assign running     = enable && (state_q == WAIT || state_q == WINDUP || state_q == RECOVER);
  assign tick        = running && (div_q == 28'd0);
  assign reload_val  = aggressive ? 28'(AGGR_DIV - 1) : 28'(CALM_DIV - 1);
  assign move_thresh = aggressive ? 3'(AGGR_MOVES) : 3'(CALM_MOVES);
  assign timed_state_d = (state_d == WAIT || state_d == WINDUP || state_d == RECOVER);

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    move_cnt_d     = move_cnt_q;
    phase_cnt_d    = phase_cnt_q;
    strike_count_d = strike_count_q;

    if (dead) begin
      // A strike accepted in the same cycle as death still counts.
      state_d = DEAD;
      if (state_q == STRIKE && strike_ready) begin
        strike_count_d = strike_count_q + 4'd1;
      end
    end else if (enable) begin
      if (running) begin
        div_d = tick ? reload_val : div_q - 28'd1;
      end
      case (state_q)
        WAIT: begin
          if (tick) state_d = MOVE;
        end
        MOVE: begin
          move_cnt_d = (move_cnt_q == 3'd7) ? 3'd7 : move_cnt_q + 3'd1;
          state_d    = DRAW;
        end
        DRAW: begin
          if (draw_done) begin
            if (move_cnt_q >= move_thresh) begin
              state_d    = WINDUP;
              move_cnt_d = 3'd0;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WINDUP: begin
          if (tick) begin
            if (phase_cnt_q == 4'(WINDUP_TICKS - 1)) state_d = STRIKE;
            else phase_cnt_d = phase_cnt_q + 4'd1;
          end
        end
        STRIKE: begin
          if (strike_ready) begin
            strike_count_d = strike_count_q + 4'd1;
            state_d        = RECOVER;
          end
        end
        RECOVER: begin
          if (tick) begin
            if (phase_cnt_q == 4'(RECOVER_TICKS - 1)) state_d = WAIT;
            else phase_cnt_d = phase_cnt_q + 4'd1;
          end
        end
        DEAD:    state_d = DEAD;
        default: state_d = WAIT;
      endcase
      // Every entry into a timed state starts a fresh interval.
      if (state_d != state_q && timed_state_d) begin
        div_d       = reload_val;
        phase_cnt_d = 4'd0;
      end
    end
  end

  // Outputs are registered decodes of the next state, so they track state_q exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT;
      div_q          <= 28'(CALM_DIV - 1);
      move_cnt_q     <= 3'd0;
      phase_cnt_q    <= 4'd0;
      strike_count_q <= 4'd0;
      move_pulse_q   <= 1'b0;
      draw_req_q     <= 1'b0;
      telegraph_q    <= 1'b0;
      strike_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      move_cnt_q     <= move_cnt_d;
      phase_cnt_q    <= phase_cnt_d;
      strike_count_q <= strike_count_d;
      move_pulse_q   <= (state_d == MOVE) && (state_q != MOVE);
      draw_req_q     <= (state_d == DRAW);
      telegraph_q    <= (state_d == WINDUP);
      strike_valid_q <= (state_d == STRIKE);
    end
  end

  assign move_pulse   = move_pulse_q;
  assign draw_req     = draw_req_q;
  assign telegraph    = telegraph_q;
  assign strike_valid = strike_valid_q;
  assign strike_count = strike_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_enemy_action_scheduler.sv
// Scoreboarded bench for enemy_action_scheduler: move pulses and strike transfers
// are queued with hand-computed cycle numbers and checked by a separate monitor.
module tb_enemy_action_scheduler;

  localparam int CALM_DIV = 4;
  localparam int AGGR_DIV = 2;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       aggressive;
  logic       dead;
  logic       move_pulse;
  logic       draw_req;
  logic       draw_done;
  logic       telegraph;
  logic       strike_valid;
  logic       strike_ready;
  logic [3:0] strike_count;
  logic [2:0] state_dbg;

  enemy_action_scheduler #(
    .CALM_DIV(CALM_DIV),
    .AGGR_DIV(AGGR_DIV),
    .CALM_MOVES(4),
    .AGGR_MOVES(2),
    .WINDUP_TICKS(2),
    .RECOVER_TICKS(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .aggressive(aggressive),
    .dead(dead),
    .move_pulse(move_pulse),
    .draw_req(draw_req),
    .draw_done(draw_done),
    .telegraph(telegraph),
    .strike_valid(strike_valid),
    .strike_ready(strike_ready),
    .strike_count(strike_count),
    .state_dbg(state_dbg)
  );

  typedef struct {
    bit isStrike;
    int cyc;
    int cnt;
  } ev_t;

  ev_t sbQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;
  bit  autoAck = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle number: count of active edges since reset was released.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Draw engine model: acks in the first cycle draw_req is seen, unless withheld.
  initial begin
    draw_done = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      draw_done = autoAck & draw_req;
    end
  end

  task automatic checkEvent(input bit isStrike);
    ev_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s at cycle %0d: got event, expected none",
               isStrike ? "strike" : "move", cyc);
    end else begin
      e = sbQ.pop_front();
      if (e.isStrike != isStrike || e.cyc != cyc ||
          (isStrike && int'(strike_count) != e.cnt)) begin
        errors++;
        $display("[TB] FAIL event: got %s@%0d count=%0d, expected %s@%0d count=%0d",
                 isStrike ? "strike" : "move", cyc, strike_count,
                 e.isStrike ? "strike" : "move", e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor samples just after the negedge, where inputs for the next edge are settled.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (move_pulse) checkEvent(1'b0);
        if (strike_valid && strike_ready) checkEvent(1'b1);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expectMove(input int c);
    ev_t e;
    e.isStrike = 1'b0; e.cyc = c; e.cnt = 0;
    sbQ.push_back(e);
  endtask

  task automatic expectStrike(input int c, input int n);
    ev_t e;
    e.isStrike = 1'b1; e.cyc = c; e.cnt = n;
    sbQ.push_back(e);
  endtask

  task automatic waitNeg(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic applyStimulus(input bit aggr, input bit ready, input bit ack);
    @(negedge clock);
    reset        = 1'b1;
    enable       = 1'b1;
    aggressive   = aggr;
    dead         = 1'b0;
    strike_ready = ready;
    autoAck      = ack;
    sbQ.delete();
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset state_dbg", int'(state_dbg), 0);
    checkOutput("reset outputs", int'({move_pulse, draw_req, telegraph, strike_valid}), 0);
    checkOutput("reset strike_count", int'(strike_count), 0);
    reset = 1'b0;
  endtask

  task automatic endScenario(input string name);
    checkOutput({name, " queue drained"}, sbQ.size(), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; aggressive = 1'b0; dead = 1'b0; strike_ready = 1'b0;

    // Calm cadence: moves every 6 cycles, attack after the 4th move.
    applyStimulus(1'b0, 1'b1, 1'b1);
    expectMove(4); expectMove(10); expectMove(16); expectMove(22);
    expectStrike(32, 0);
    expectMove(41); expectMove(47);
    waitNeg(23);
    checkOutput("calm draw_req", int'(draw_req), 1);
    checkOutput("calm state DRAW", int'(state_dbg), 2);
    waitNeg(24);
    checkOutput("calm telegraph", int'(telegraph), 1);
    checkOutput("calm state WINDUP", int'(state_dbg), 3);
    waitNeg(31);
    checkOutput("calm still WINDUP", int'(state_dbg), 3);
    waitNeg(32);
    checkOutput("calm strike_valid", int'(strike_valid), 1);
    waitNeg(33);
    checkOutput("calm strike_count", int'(strike_count), 1);
    checkOutput("calm strike_valid drop", int'(strike_valid), 0);
    checkOutput("calm state RECOVER", int'(state_dbg), 5);
    waitNeg(36);
    checkOutput("calm recover end", int'(state_dbg), 5);
    waitNeg(37);
    checkOutput("calm back to WAIT", int'(state_dbg), 0);
    waitNeg(50);
    endScenario("calm");

    // Backpressure on both handshakes.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectMove(4); expectMove(10); expectMove(16); expectMove(22);
    expectStrike(41, 0);
    expectMove(50); expectMove(76);
    waitNeg(41);
    checkOutput("bp strike_valid held", int'(strike_valid), 1);
    checkOutput("bp count held", int'(strike_count), 0);
    strike_ready = 1'b1;
    waitNeg(42);
    checkOutput("bp count after transfer", int'(strike_count), 1);
    waitNeg(50);
    autoAck = 1'b0;
    waitNeg(70);
    checkOutput("bp draw_req held", int'(draw_req), 1);
    checkOutput("bp state DRAW", int'(state_dbg), 2);
    autoAck = 1'b1;
    waitNeg(80);
    endScenario("backpressure");

    // Aggressive from reset: first interval still calm, then 2-cycle ticks.
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectMove(4); expectMove(8); expectStrike(14, 0);
    expectMove(19); expectMove(23); expectStrike(29, 1);
    waitNeg(10);
    checkOutput("aggr telegraph", int'(telegraph), 1);
    waitNeg(32);
    endScenario("aggressive");

    // Calm to aggressive with three moves banked.
    applyStimulus(1'b0, 1'b1, 1'b1);
    expectMove(4); expectMove(10); expectMove(16); expectStrike(22, 0);
    waitNeg(16);
    aggressive = 1'b1;
    waitNeg(18);
    checkOutput("switch WINDUP", int'(state_dbg), 3);
    waitNeg(25);
    endScenario("switch");

    // Death while a strike is being accepted.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectMove(4); expectMove(10); expectMove(16); expectMove(22);
    expectStrike(34, 0);
    waitNeg(34);
    dead = 1'b1;
    strike_ready = 1'b1;
    waitNeg(35);
    dead = 1'b0;
    checkOutput("dead state", int'(state_dbg), 6);
    checkOutput("dead count", int'(strike_count), 1);
    checkOutput("dead outputs", int'({move_pulse, draw_req, telegraph, strike_valid}), 0);
    waitNeg(60);
    checkOutput("dead absorbing", int'(state_dbg), 6);
    checkOutput("dead count held", int'(strike_count), 1);
    endScenario("dead strike");

    // Death during a pending draw request.
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectMove(4);
    waitNeg(6);
    checkOutput("dead-draw req before", int'(draw_req), 1);
    dead = 1'b1;
    waitNeg(7);
    dead = 1'b0;
    checkOutput("dead-draw req dropped", int'(draw_req), 0);
    checkOutput("dead-draw state", int'(state_dbg), 6);
    endScenario("dead draw");

    // Freeze for 7 cycles mid-WINDUP, then reset during STRIKE.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectMove(4); expectMove(10); expectMove(16); expectMove(22);
    waitNeg(25);
    enable = 1'b0;
    waitNeg(30);
    checkOutput("freeze telegraph", int'(telegraph), 1);
    checkOutput("freeze state", int'(state_dbg), 3);
    waitNeg(32);
    enable = 1'b1;
    waitNeg(38);
    checkOutput("freeze shifted WINDUP", int'(state_dbg), 3);
    waitNeg(39);
    checkOutput("freeze shifted STRIKE", int'(state_dbg), 4);
    checkOutput("freeze strike_valid", int'(strike_valid), 1);
    waitNeg(41);
    reset = 1'b1;
    #1;
    checkOutput("async reset strike_valid", int'(strike_valid), 0);
    checkOutput("async reset state", int'(state_dbg), 0);
    checkOutput("async reset count", int'(strike_count), 0);
    endScenario("freeze");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
